deck_dealer: RTL and testbench

DECK_DEALER -- requirements
Module: deck_dealer

---
 rtl/deck_dealer.sv | 100 ++++++++++
 tb/tb_deck_dealer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/deck_dealer.sv
// deck_dealer: builds an identity deck, Fisher-Yates shuffles it with an LFSR, then deals one card per request.
module deck_dealer #(
    parameter int DECK_SIZE = 52,
    parameter int ADDR_W = 6,
    parameter int SEED_W = 12,
    parameter logic [SEED_W-1:0] TAPS = SEED_W'(12'h829)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEED_W-1:0] seed,
    input  logic              shuffle,
    input  logic              deal_req,
    output logic [ADDR_W-1:0] card,
    output logic              card_valid,
    output logic              deal_err,
    output logic              busy,
    output logic              ready,
    output logic              empty,
    output logic [ADDR_W:0]   remaining
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_SHUF = 2'd2;
    localparam logic [1:0] S_READY = 2'd3;
    localparam int MW = SEED_W > ADDR_W ? SEED_W : ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DECK_SIZE - 1);
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DECK_SIZE);

    logic [1:0]        state;
    logic [SEED_W-1:0] lfsr;
    logic [SEED_W-1:0] lfsr_next;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] j;
    logic [ADDR_W:0]   ptr;
    logic [ADDR_W-1:0] perm [DECK_SIZE];
    logic              take_shuffle;
    logic              can_deal;

    assign lfsr_next = {lfsr[SEED_W-2:0], ^(lfsr & TAPS)};
    // MW is wide enough for both the LFSR value and the divisor i+1 up to DECK_SIZE
    assign j = ADDR_W'(MW'(lfsr) % (MW'(i) + MW'(1)));
    assign take_shuffle = shuffle && (state == S_IDLE || state == S_READY);
    assign can_deal = state == S_READY && ptr != FULL;
    assign busy = state == S_INIT || state == S_SHUF;
    assign ready = state == S_READY;
    assign empty = ready && ptr == FULL;
    assign remaining = ready ? FULL - ptr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            lfsr <= SEED_W'(1);
            i <= '0;
            ptr <= '0;
            card <= '0;
            card_valid <= 1'b0;
            deal_err <= 1'b0;
        end else begin
            card_valid <= 1'b0;
            deal_err <= 1'b0;
            if (take_shuffle) begin
                lfsr <= (seed == '0) ? SEED_W'(1) : seed;
                i <= '0;
                state <= S_INIT;
            end else begin
                if (deal_req) begin
                    if (can_deal) begin
                        card <= perm[ptr[ADDR_W-1:0]];
                        card_valid <= 1'b1;
                        ptr <= ptr + (ADDR_W + 1)'(1);
                    end else begin
                        deal_err <= 1'b1;
                    end
                end
                if (state == S_INIT) begin
                    if (i == LAST) state <= S_SHUF;
                    else i <= i + ADDR_W'(1);
                end
                if (state == S_SHUF) begin
                    lfsr <= lfsr_next;
                    i <= i - ADDR_W'(1);
                    if (i == ADDR_W'(1)) begin
                        state <= S_READY;
                        ptr <= '0;
                    end
                end
            end
        end
    end

    // deck storage has no reset; only a completed INIT gives it meaning
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            perm[i] <= i;
        end else if (state == S_SHUF) begin
            perm[i] <= perm[j];
            perm[j] <= perm[i];
        end
    end
endmodule

// File: tb/tb_deck_dealer.sv
// tb_deck_dealer: default and 8-card dealers on shared random stimulus, checked every cycle against a behavioural model.
module tb_deck_dealer;
    typedef int deck_t [64];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        shuffle = 1'b0;
    logic        deal_req = 1'b0;
    logic [11:0] seed = '0;
    logic [5:0]  b_card;
    logic        b_cv, b_err, b_busy, b_ready, b_empty;
    logic [6:0]  b_rem;
    logic [2:0]  s_card;
    logic        s_cv, s_err, s_busy, s_ready, s_empty;
    logic [3:0]  s_rem;

    int    nn [2] = '{52, 8};
    int    m_left [2];
    int    m_dealt [2];
    int    m_card [2];
    bit    m_ready [2];
    bit    m_valid [2];
    bit    m_err [2];
    deck_t m_deck [2];
    bit    started = 1'b0;
    int    total = 0;
    int    bad = 0;

    deck_dealer u_big (
        .clk(clk), .rst(rst), .seed(seed), .shuffle(shuffle), .deal_req(deal_req),
        .card(b_card), .card_valid(b_cv), .deal_err(b_err), .busy(b_busy),
        .ready(b_ready), .empty(b_empty), .remaining(b_rem)
    );

    deck_dealer #(.DECK_SIZE(8), .ADDR_W(3), .SEED_W(12)) u_small (
        .clk(clk), .rst(rst), .seed(seed), .shuffle(shuffle), .deal_req(deal_req),
        .card(s_card), .card_valid(s_cv), .deal_err(s_err), .busy(s_busy),
        .ready(s_ready), .empty(s_empty), .remaining(s_rem)
    );

    always #5 clk = ~clk;

    function automatic int lstep(input int l);
        return ((l << 1) & 'hFFF) | ($countones(l & 'h829) & 1);
    endfunction

    task automatic build(input int n, input int sd, output deck_t d);
        int l = (sd == 0) ? 1 : sd;
        int t;
        int j;
        for (int x = 0; x < 64; x++) d[x] = x;
        for (int x = n - 1; x >= 1; x--) begin
            j = l % (x + 1);
            t = d[x];
            d[x] = d[j];
            d[j] = t;
            l = lstep(l);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // model: a deck is fixed the moment a shuffle is accepted and becomes dealable 2N-1 cycles later
    always @(posedge clk) begin
        deck_t tmp;
        if (rst) started = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_left[k] = 0;
                m_ready[k] = 1'b0;
                m_dealt[k] = 0;
                m_card[k] = 0;
                m_valid[k] = 1'b0;
                m_err[k] = 1'b0;
            end else begin
                m_valid[k] = 1'b0;
                m_err[k] = 1'b0;
                if (shuffle && m_left[k] == 0) begin
                    build(nn[k], int'(seed), tmp);
                    m_deck[k] = tmp;
                    m_left[k] = 2 * nn[k] - 1;
                    m_ready[k] = 1'b0;
                end else begin
                    if (deal_req) begin
                        if (m_ready[k] && m_dealt[k] < nn[k]) begin
                            m_card[k] = m_deck[k][m_dealt[k]];
                            m_valid[k] = 1'b1;
                            m_dealt[k]++;
                        end else begin
                            m_err[k] = 1'b1;
                        end
                    end
                    if (m_left[k] > 0) begin
                        m_left[k]--;
                        if (m_left[k] == 0) begin
                            m_ready[k] = 1'b1;
                            m_dealt[k] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic cmp(input string p, input int k, input int cv, input int err, input int bsy,
                       input int rdy, input int emp, input int rem, input int crd);
        int n = nn[k];
        chk({p, "_valid"}, cv, int'(m_valid[k]));
        chk({p, "_err"}, err, int'(m_err[k]));
        chk({p, "_busy"}, bsy, int'(m_left[k] > 0));
        chk({p, "_ready"}, rdy, int'(m_ready[k]));
        chk({p, "_empty"}, emp, int'(m_ready[k] && m_dealt[k] == n));
        chk({p, "_remaining"}, rem, m_ready[k] ? n - m_dealt[k] : 0);
        chk({p, "_card"}, crd, m_card[k]);
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp("big", 0, b_cv, b_err, b_busy, b_ready, b_empty, b_rem, b_card);
            cmp("small", 1, s_cv, s_err, s_busy, s_ready, s_empty, s_rem, s_card);
        end
    end

    task automatic step(input bit sh, input bit dr, input bit rs, input logic [11:0] sd);
        shuffle = sh;
        deal_req = dr;
        rst = rs;
        seed = sd;
        @(posedge clk);
        #1;
        shuffle = 1'b0;
        deal_req = 1'b0;
        rst = 1'b0;
    endtask

    task automatic wait_big(output int cnt);
        cnt = 0;
        while (b_busy && cnt < 400) begin
            cnt++;
            step(0, 0, 0, seed);
        end
    endtask

    task automatic deal_big(output int sq [52]);
        for (int x = 0; x < 52; x++) begin
            step(0, 1, 0, seed);
            chk("deal_valid", b_cv, 1);
            chk("deal_remaining", b_rem, 51 - x);
            sq[x] = b_cv ? int'(b_card) : -1;
        end
    endtask

    initial begin
        int cnt;
        int diffs;
        int seen;
        int seq_a [52];
        int seq_b [52];
        int seq_c [52];
        int sq [8];
        int lit [8] = '{4, 6, 5, 2, 0, 7, 3, 1};
        logic [63:0] mask;
        deck_t md;
        build(8, 1, md);
        diffs = 0;
        for (int x = 0; x < 8; x++) if (md[x] != lit[x]) diffs++;
        chk("model_deck8_seed1", diffs, 0);
        chk("model_lfsr_step_800", lstep('h800), 1);
        step(0, 0, 1, 12'h000);
        step(0, 0, 1, 12'h000);
        chk("rst_card", b_card, 0);
        chk("rst_valid", b_cv, 0);
        chk("rst_err", b_err, 0);
        chk("rst_busy", b_busy, 0);
        chk("rst_ready", b_ready, 0);
        chk("rst_empty", b_empty, 0);
        chk("rst_remaining", b_rem, 0);

        step(1, 0, 0, 12'h5A3);
        wait_big(cnt);
        chk("busy_len", cnt, 103);
        chk("ready_after", b_ready, 1);
        chk("remaining_full", b_rem, 52);
        chk("empty_full", b_empty, 0);
        deal_big(seq_a);
        mask = '0;
        for (int x = 0; x < 52; x++) if (seq_a[x] >= 0 && seq_a[x] < 52) mask[seq_a[x]] = 1'b1;
        seen = $countones(mask);
        chk("perm_big", seen, 52);
        chk("empty_after", b_empty, 1);
        step(0, 1, 0, seed);
        chk("deal53_err", b_err, 1);
        chk("deal53_valid", b_cv, 0);

        step(1, 0, 0, 12'h001);
        cnt = 0;
        while (s_busy && cnt < 100) begin
            cnt++;
            step(0, 0, 0, seed);
        end
        chk("small_busy_len", cnt, 15);
        for (int x = 0; x < 8; x++) begin
            step(0, 1, 0, seed);
            sq[x] = s_cv ? int'(s_card) : -1;
        end
        diffs = 0;
        for (int x = 0; x < 8; x++) if (sq[x] != lit[x]) diffs++;
        chk("small_seed1_order", diffs, 0);
        wait_big(cnt);
        deal_big(seq_b);
        step(1, 0, 0, 12'h000);
        wait_big(cnt);
        deal_big(seq_c);
        diffs = 0;
        for (int x = 0; x < 52; x++) if (seq_b[x] != seq_c[x]) diffs++;
        chk("seed0_eq_seed1", diffs, 0);
        step(1, 0, 0, 12'h5A3);
        wait_big(cnt);
        deal_big(seq_c);
        diffs = 0;
        for (int x = 0; x < 52; x++) if (seq_a[x] != seq_c[x]) diffs++;
        chk("reseed_same_order", diffs, 0);

        step(1, 0, 0, 12'h5A3);
        cnt = 0;
        while (b_busy && cnt < 400) begin
            cnt++;
            if (cnt == 10) begin
                step(0, 1, 0, seed);
                chk("err_in_init", b_err, 1);
            end else if (cnt == 60) begin
                step(1, 1, 0, 12'h123);
                chk("err_in_shuf", b_err, 1);
            end else begin
                step(0, 0, 0, seed);
            end
        end
        chk("busy_len_ignored_shuffle", cnt, 103);

        step(1, 0, 0, 12'h0F0);
        for (int x = 0; x < 71; x++) step(0, 0, 0, seed);
        chk("busy_before_abort", b_busy, 1);
        step(0, 0, 1, seed);
        chk("abort_busy", b_busy, 0);
        chk("abort_ready", b_ready, 0);
        chk("abort_remaining", b_rem, 0);
        chk("abort_card", b_card, 0);
        step(0, 1, 0, seed);
        chk("abort_deal_err", b_err, 1);

        for (int x = 0; x < 4000; x++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1, $urandom_range(0, 999) < 2,
                 ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom));
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
